qoi_decoder: RTL and testbench
==============================

QOI_DECODER -- requirements
Module: qoi_decoder

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous active-low reset; clears all state regardless of clk.
REQ-003 SHALL have ports: cs input 1 chip select; we input 1 write strobe; addr input 3 register index; data_i input 8 write data; data_o output 8 read data (combinational from addr).
REQ-004 SHALL treat one cycle with cs=1 as exactly one bus access (6502 cycle); cs=0 cycles SHALL have no effect.
REQ-005 SHALL decode write map: addr0 = encoded QOI byte in; addr3 bit7 = start; addr4..7 = pixel count target size[29:0] (addr7 bits 5:0 used), little-endian.
REQ-006 SHALL decode read map: addr0 = decoded pixel byte; addr3 = {working, err, 2'b0, byte_idx[1:0], out_flag, in_flag}; addr4..7 = emitted pixel count[29:0], little-endian, upper bits 0; addr1, addr2 read 0x00.

Function
REQ-007 SHALL implement states IDLE, OPCODE (await first byte), ARGS (await operand bytes), EMIT (pixel available to host).
REQ-008 Start write (addr3, bit7=1) in any state SHALL on the next cycle: clear count, err, byte_idx, run; set prev={r0,g0,b0,a255}; clear all 64 index entries to 0; enter OPCODE, or IDLE if size==0.
REQ-009 in_flag SHALL be 1 exactly in OPCODE and ARGS; out_flag exactly in EMIT; working in any non-IDLE state.
REQ-010 Byte write to addr0 in OPCODE/ARGS SHALL be accepted that edge; in IDLE/EMIT SHALL be dropped and set sticky err (EMIT only).
REQ-011 OPCODE decode: 0xFE RGB (3 args, alpha=prev.a); 0xFF RGBA (4 args); 00iiiiii INDEX; 01rrggbb DIFF; 10gggggg LUMA (1 arg); 11nnnnnn RUN (n+1 pixels, n in 0..61).
REQ-012 DIFF SHALL compute r=prev.r+rr-2, g=prev.g+gg-2, b=prev.b+bb-2, all mod 256, alpha unchanged.
REQ-013 LUMA SHALL compute dg=g6-32; r=prev.r+dg+(arg[7:4]-8); g=prev.g+dg; b=prev.b+dg+(arg[3:0]-8), mod 256, alpha unchanged.
REQ-014 INDEX SHALL output index[iiiiii]; RUN SHALL output prev.
REQ-015 Decoded pixel SHALL be registered on the edge accepting the op's final byte; EMIT SHALL be entered on that edge (latency 1 cycle to out_flag).
REQ-016 On EMIT entry: prev<=pixel; index[(r*3+g*5+b*7+a*11) mod 64]<=pixel; count<=count+1.
REQ-017 In EMIT, addr0 read SHALL return byte byte_idx (0=r,1=g,2=b,3=a) and advance byte_idx on that edge; read of addr0 outside EMIT SHALL return 0x00 and not advance.
REQ-018 On the read with byte_idx==3: byte_idx<=0; if count==size -> IDLE; else if run remaining>0 -> decrement run, stay EMIT with same pixel, apply REQ-016 again; else -> OPCODE.
REQ-019 RUN reaching size mid-run SHALL discard remaining run and return to IDLE after last pixel read.
REQ-020 Writes to addr3/4..7 SHALL update registers at any time; size changes take effect at the next REQ-018 comparison.
REQ-021 Start and addr0 read in same cycle: start SHALL win.

Reset
REQ-022 While rst=0: state=IDLE, count=0, byte_idx=0, run=0, err=0, prev={0,0,0,255}, index entries 0, control/size registers 0; data_o for addr3 = 0x00.
REQ-023 Reset deassertion mid-decode SHALL leave block in IDLE requiring a new start.

Verification
REQ-024 size=1, start, write FE 10 20 30 -> out_flag 1 cycle after 0x30; reads addr0 = 10,20,30,FF; then addr3=0x00 working=0, count=1.
REQ-025 size=3, start, write FF 01 02 03 80 then 7F -> pixel (1,2,3,0x80) then DIFF 0x7F -> (2,3,4,0x80); count=2, in_flag=1.
REQ-026 size=4 after pixel (10,10,10,FF): write C2 -> three pixels (10,10,10,FF) emitted back-to-back, in_flag only after third alpha read; size reached -> IDLE.
REQ-027 LUMA: prev (0,0,0,FF), write A5 then 0x97 -> dg=5, pixel (6,5,4,FF); hash=(18+25+28+2805) mod 64=60; subsequent INDEX 0x3C returns (6,5,4,FF).
REQ-028 Write 0xAA to addr0 during EMIT -> err=1 (addr3 bit6), pixel unchanged; next start clears err.
REQ-029 Assert rst=0 asynchronously between RGB arg bytes -> addr3 reads 0x00 immediately, count 0, further byte writes ignored until start.

Source files
------------

// File: rtl/qoi_decoder_if.sv
// rtl/qoi_decoder_if.sv - host bus bundle for the QOI decoder register window
//
// Purpose: groups the 6502-style register bus of qoi_decoder.
// Signals:
//   cs     chip select, one cycle with cs=1 is one bus access
//   we     write strobe (1 = write, 0 = read)
//   addr   register index 0..7
//   data_i write data from host
//   data_o read data to host, combinational from addr
// Modports: master (host side), slave (decoder side).

interface qoi_decoder_if;
   logic       cs;
   logic       we;
   logic [2:0] addr;
   logic [7:0] data_i;
   logic [7:0] data_o;

   modport master (output cs, output we, output addr, output data_i, input data_o);
   modport slave  (input cs, input we, input addr, input data_i, output data_o);
endinterface

// File: rtl/qoi_decoder.sv
// rtl/qoi_decoder.sv - byte-at-a-time QOI image stream decoder behind a register window
//
// Purpose: accepts encoded QOI bytes through register 0, decodes one pixel per op
// (RUN ops produce several), and hands each pixel back to the host as four
// byte reads of register 0 (r, g, b, a).
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  qoi_decoder_if.slave register bus
// Write map: 0 = encoded byte, 3 bit7 = start, 4..7 = target pixel count (LE, 30 bits)
// Read map:  0 = pixel byte, 3 = {working, err, 00, byte_idx, out_flag, in_flag},
//            4..7 = emitted pixel count (LE), 1/2 = 0x00

module qoi_decoder (
   input  logic          clk,
   input  logic          rst,
   qoi_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_OPCODE = 2'd1,
      S_ARGS   = 2'd2,
      S_EMIT   = 2'd3
   } state_t;

   localparam logic [31:0] PREV_INIT = 32'h0000_00FF;

   state_t      state_q, state_d;
   logic [29:0] count_q, count_d;
   logic [29:0] size_q, size_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [5:0]  run_q, run_d;
   logic        err_q, err_d;
   logic [31:0] prev_q, prev_d;
   logic [31:0] pix_q, pix_d;
   logic [7:0]  op_q, op_d;
   logic [1:0]  arg_cnt_q, arg_cnt_d;
   logic [7:0]  arg0_q, arg0_d;
   logic [7:0]  arg1_q, arg1_d;
   logic [7:0]  arg2_q, arg2_d;
   logic [31:0] index_q [64];

   logic        wr_acc, rd_acc, start, byte_wr, byte_rd;
   logic        emit, clr_index;
   logic [31:0] emit_pix;
   logic [5:0]  hash;
   logic [1:0]  last_arg;
   logic [7:0]  dg;
   logic [7:0]  pr, pg, pb, pa;

   assign wr_acc  = bus.cs &  bus.we;
   assign rd_acc  = bus.cs & ~bus.we;
   assign start   = wr_acc && (bus.addr == 3'd3) && bus.data_i[7];
   assign byte_wr = wr_acc && (bus.addr == 3'd0);
   assign byte_rd = rd_acc && (bus.addr == 3'd0);

   assign pr = prev_q[31:24];
   assign pg = prev_q[23:16];
   assign pb = prev_q[15:8];
   assign pa = prev_q[7:0];

   // Index of the final operand byte: RGB has 3, RGBA 4, LUMA 1.
   assign last_arg = (op_q == 8'hFE) ? 2'd2 :
                     (op_q == 8'hFF) ? 2'd3 : 2'd0;

   // LUMA green delta, biased by 32
   assign dg = {2'b00, op_q[5:0]} - 8'd32;

   // Hash depends only on the low 6 bits of each channel once reduced mod 64.
   assign hash = emit_pix[29:24] * 6'd3 + emit_pix[21:16] * 6'd5 +
                 emit_pix[13:8]  * 6'd7 + emit_pix[5:0]   * 6'd11;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      size_d     = size_q;
      byte_idx_d = byte_idx_q;
      run_d      = run_q;
      err_d      = err_q;
      prev_d     = prev_q;
      pix_d      = pix_q;
      op_d       = op_q;
      arg_cnt_d  = arg_cnt_q;
      arg0_d     = arg0_q;
      arg1_d     = arg1_q;
      arg2_d     = arg2_q;
      emit       = 1'b0;
      emit_pix   = pix_q;
      clr_index  = 1'b0;

      if (wr_acc) begin
         case (bus.addr)
            3'd4:    size_d[7:0]   = bus.data_i;
            3'd5:    size_d[15:8]  = bus.data_i;
            3'd6:    size_d[23:16] = bus.data_i;
            3'd7:    size_d[29:24] = bus.data_i[5:0];
            default: ;
         endcase
      end

      if (start) begin
         // Start overrides any concurrent pixel read or byte write.
         count_d    = '0;
         err_d      = 1'b0;
         byte_idx_d = '0;
         run_d      = '0;
         arg_cnt_d  = '0;
         prev_d     = PREV_INIT;
         clr_index  = 1'b1;
         state_d    = (size_q == '0) ? S_IDLE : S_OPCODE;
      end else begin
         case (state_q)
            S_OPCODE: begin
               if (byte_wr) begin
                  op_d      = bus.data_i;
                  arg_cnt_d = '0;
                  if (bus.data_i == 8'hFE || bus.data_i == 8'hFF ||
                      bus.data_i[7:6] == 2'b10) begin
                     state_d = S_ARGS;
                  end else begin
                     emit = 1'b1;
                     case (bus.data_i[7:6])
                        2'b00: emit_pix = index_q[bus.data_i[5:0]];
                        2'b01: emit_pix = {pr + {6'd0, bus.data_i[5:4]} - 8'd2,
                                           pg + {6'd0, bus.data_i[3:2]} - 8'd2,
                                           pb + {6'd0, bus.data_i[1:0]} - 8'd2,
                                           pa};
                        default: begin
                           emit_pix = prev_q;
                           run_d    = bus.data_i[5:0];
                        end
                     endcase
                  end
               end
            end
            S_ARGS: begin
               if (byte_wr) begin
                  if (arg_cnt_q == last_arg) begin
                     emit = 1'b1;
                     if (op_q == 8'hFE)
                        emit_pix = {arg0_q, arg1_q, bus.data_i, pa};
                     else if (op_q == 8'hFF)
                        emit_pix = {arg0_q, arg1_q, arg2_q, bus.data_i};
                     else
                        emit_pix = {pr + dg + {4'd0, bus.data_i[7:4]} - 8'd8,
                                    pg + dg,
                                    pb + dg + {4'd0, bus.data_i[3:0]} - 8'd8,
                                    pa};
                  end else begin
                     case (arg_cnt_q)
                        2'd0:    arg0_d = bus.data_i;
                        2'd1:    arg1_d = bus.data_i;
                        default: arg2_d = bus.data_i;
                     endcase
                     arg_cnt_d = arg_cnt_q + 2'd1;
                  end
               end
            end
            S_EMIT: begin
               if (byte_wr)
                  err_d = 1'b1;
               if (byte_rd) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     if (count_q == size_q) begin
                        state_d = S_IDLE;
                        run_d   = '0;
                     end else if (run_q != '0) begin
                        run_d    = run_q - 6'd1;
                        emit     = 1'b1;
                        emit_pix = pix_q;
                     end else begin
                        state_d = S_OPCODE;
                     end
                  end
               end
            end
            default: ;
         endcase

         if (emit) begin
            state_d = S_EMIT;
            pix_d   = emit_pix;
            prev_d  = emit_pix;
            count_d = count_q + 30'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         size_q     <= '0;
         byte_idx_q <= '0;
         run_q      <= '0;
         err_q      <= 1'b0;
         prev_q     <= PREV_INIT;
         pix_q      <= '0;
         op_q       <= '0;
         arg_cnt_q  <= '0;
         arg0_q     <= '0;
         arg1_q     <= '0;
         arg2_q     <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         size_q     <= size_d;
         byte_idx_q <= byte_idx_d;
         run_q      <= run_d;
         err_q      <= err_d;
         prev_q     <= prev_d;
         pix_q      <= pix_d;
         op_q       <= op_d;
         arg_cnt_q  <= arg_cnt_d;
         arg0_q     <= arg0_d;
         arg1_q     <= arg1_d;
         arg2_q     <= arg2_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 64; i++)
            index_q[i] <= '0;
      end else if (clr_index) begin
         for (int i = 0; i < 64; i++)
            index_q[i] <= '0;
      end else if (emit) begin
         index_q[hash] <= emit_pix;
      end
   end

   always_comb begin
      bus.data_o = 8'h00;
      case (bus.addr)
         3'd0: begin
            if (state_q == S_EMIT) begin
               case (byte_idx_q)
                  2'd0:    bus.data_o = pix_q[31:24];
                  2'd1:    bus.data_o = pix_q[23:16];
                  2'd2:    bus.data_o = pix_q[15:8];
                  default: bus.data_o = pix_q[7:0];
               endcase
            end
         end
         3'd3: bus.data_o = {state_q != S_IDLE, err_q, 2'b00, byte_idx_q,
                             state_q == S_EMIT,
                             (state_q == S_OPCODE) || (state_q == S_ARGS)};
         3'd4: bus.data_o = count_q[7:0];
         3'd5: bus.data_o = count_q[15:8];
         3'd6: bus.data_o = count_q[23:16];
         3'd7: bus.data_o = {2'b00, count_q[29:24]};
         default: bus.data_o = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_qoi_decoder.sv
// tb/tb_qoi_decoder.sv - directed self-checking bench for qoi_decoder

module tb_qoi_decoder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   qoi_decoder_if bus ();

   qoi_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d;
      @(posedge clk);
      #1;
      bus.cs = 1'b0; bus.we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
      #1;
      check(tag, {24'd0, bus.data_o}, {24'd0, exp});
      @(posedge clk);
      #1;
      bus.cs = 1'b0;
   endtask

   task automatic peek(input logic [2:0] a, input logic [7:0] exp, input string tag);
      bus.cs = 1'b0; bus.addr = a;
      #1;
      check(tag, {24'd0, bus.data_o}, {24'd0, exp});
   endtask

   task automatic rd_pix(input logic [31:0] p, input string tag);
      rd(3'd0, p[31:24], {tag, ".r"});
      rd(3'd0, p[23:16], {tag, ".g"});
      rd(3'd0, p[15:8],  {tag, ".b"});
      rd(3'd0, p[7:0],   {tag, ".a"});
   endtask

   task automatic set_size(input logic [29:0] n);
      wr(3'd4, n[7:0]);
      wr(3'd5, n[15:8]);
      wr(3'd6, n[23:16]);
      wr(3'd7, {2'b00, n[29:24]});
   endtask

   task automatic do_start();
      wr(3'd3, 8'h80);
   endtask

   initial begin
      bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 3'd0; bus.data_i = 8'h00;
      repeat (2) @(negedge clk);
      peek(3'd3, 8'h00, "reset_ctrl");
      peek(3'd4, 8'h00, "reset_count");
      peek(3'd0, 8'h00, "reset_pix");
      @(negedge clk);
      rst = 1'b1;

      // RGB single pixel
      set_size(30'd1);
      do_start();
      peek(3'd3, 8'h81, "rgb_opcode_state");
      wr(3'd0, 8'hFE); wr(3'd0, 8'h10); wr(3'd0, 8'h20);
      peek(3'd3, 8'h81, "rgb_args_state");
      wr(3'd0, 8'h30);
      peek(3'd3, 8'h82, "rgb_emit_latency");
      rd_pix(32'h102030FF, "rgb_pix");
      peek(3'd3, 8'h00, "rgb_done_idle");
      peek(3'd4, 8'h01, "rgb_count");
      peek(3'd1, 8'h00, "addr1_zero");

      // RGBA then DIFF
      set_size(30'd3);
      do_start();
      wr(3'd0, 8'hFF); wr(3'd0, 8'h01); wr(3'd0, 8'h02); wr(3'd0, 8'h03); wr(3'd0, 8'h80);
      rd_pix(32'h01020380, "rgba_pix");
      wr(3'd0, 8'h7F);
      rd_pix(32'h02030480, "diff_pix");
      peek(3'd4, 8'h02, "diff_count");
      peek(3'd3, 8'h81, "diff_in_flag");

      // RUN of three after an RGB pixel, size reached at run end
      set_size(30'd4);
      do_start();
      wr(3'd0, 8'hFE); wr(3'd0, 8'h10); wr(3'd0, 8'h10); wr(3'd0, 8'h10);
      rd_pix(32'h101010FF, "run_seed");
      peek(3'd3, 8'h81, "run_seed_opcode");
      wr(3'd0, 8'hC2);
      rd_pix(32'h101010FF, "run_p1");
      peek(3'd3, 8'h82, "run_p1_still_emit");
      rd(3'd0, 8'h10, "run_p2.r");
      rd(3'd0, 8'h10, "run_p2.g");
      peek(3'd3, 8'h8A, "run_p2_byte_idx");
      rd(3'd0, 8'h10, "run_p2.b");
      rd(3'd0, 8'hFF, "run_p2.a");
      rd_pix(32'h101010FF, "run_p3");
      peek(3'd3, 8'h00, "run_done_idle");
      peek(3'd4, 8'h04, "run_count");

      // LUMA and INDEX recall
      set_size(30'd3);
      do_start();
      wr(3'd0, 8'hA5);
      peek(3'd3, 8'h81, "luma_args");
      wr(3'd0, 8'h97);
      rd_pix(32'h060504FF, "luma_pix");
      wr(3'd0, 8'h3C);
      rd_pix(32'h060504FF, "index_pix");
      peek(3'd4, 8'h02, "index_count");

      // Byte write during EMIT sets sticky error
      wr(3'd0, 8'h6A);
      wr(3'd0, 8'hAA);
      peek(3'd3, 8'hC2, "err_set");
      rd_pix(32'h060504FF, "err_pix_unchanged");
      peek(3'd3, 8'h40, "err_sticky_idle");
      wr(3'd0, 8'h55);
      peek(3'd3, 8'h40, "idle_write_dropped");
      do_start();
      peek(3'd3, 8'h81, "start_clears_err");
      peek(3'd4, 8'h00, "start_clears_count");

      // addr0 read outside EMIT, index cleared by start
      rd(3'd0, 8'h00, "pix_read_opcode");
      peek(3'd3, 8'h81, "no_advance_opcode");
      wr(3'd0, 8'h3C);
      rd_pix(32'h00000000, "index_cleared");
      peek(3'd4, 8'h01, "index_cleared_count");

      // Size reached mid-run discards remaining run
      set_size(30'd2);
      do_start();
      wr(3'd0, 8'hFE); wr(3'd0, 8'h01); wr(3'd0, 8'h01); wr(3'd0, 8'h01);
      rd_pix(32'h010101FF, "midrun_seed");
      wr(3'd0, 8'hC5);
      rd_pix(32'h010101FF, "midrun_p1");
      peek(3'd3, 8'h00, "midrun_idle");
      peek(3'd4, 8'h02, "midrun_count");

      // Asynchronous reset between RGB arguments
      set_size(30'd3);
      do_start();
      wr(3'd0, 8'hFE); wr(3'd0, 8'h11);
      @(negedge clk);
      #2 rst = 1'b0;
      peek(3'd3, 8'h00, "async_rst_ctrl");
      peek(3'd4, 8'h00, "async_rst_count");
      @(negedge clk);
      rst = 1'b1;
      wr(3'd0, 8'h22);
      peek(3'd3, 8'h00, "post_rst_ignored");
      do_start();
      peek(3'd3, 8'h00, "start_size0_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
